anim_frame_gen: RTL and testbench

Parametrised successor of the single-pattern cube frame generator. It produces full N×N×N LED-cube frames for one of four selectable animations, at a rate set by a programmable prescaler. Frames leave through a valid/ready handshake toward the frame buffer / layer scanner, so no frame is ever lost when the consumer stalls. It sits between the mode/speed control registers and the cube display path.

---
 rtl/anim_pkg.sv | 31 +++
 rtl/anim_prescaler.sv | 41 ++++
 rtl/anim_frame_gen.sv | 155 +++++++++++++++
 tb/tb_anim_frame_gen.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/anim_pkg.sv
// Shared constants and the per-line frame pattern for the animation frame generator.
// Latency: none (pure declarations and a combinational helper).
// Backpressure: not applicable.
package anim_pkg;

    localparam logic [1:0] MODE_LINE   = 2'd0;
    localparam logic [1:0] MODE_LAYER  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_FILL   = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        PRESENT   = 2'd2
    } state_t;

    // Frame pattern for (mode, step), evaluated one line at a time: returns
    // whether the given line index (= z*n + y) is fully lit in an n*n*n cube.
    function automatic logic pattern(input logic [1:0] mode, input int step,
                                     input int line, input int n);
        logic lit;
        lit = 1'b0;
        case (mode)
            MODE_LINE:               lit = (line == step);
            MODE_LAYER, MODE_BOUNCE: lit = ((line / n) == step);
            default:                 lit = (line < step);
        endcase
        return lit;
    endfunction

endpackage

// File: rtl/anim_prescaler.sv
// Frame-rate prescaler: one tick every (display_speed+1)*2^DIV_LEN enabled cycles.
// Latency: tick is combinational from the counter registers.
// Backpressure: clear holds both counters at zero while the frame generator is not waiting.
module anim_prescaler
    import anim_pkg::*;
#(
    parameter int DIV_LEN = 23,
    parameter int SPEED_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [SPEED_W-1:0] display_speed,
    output logic               tick
);

    logic [SPEED_W-1:0] speed_cnt;
    logic [DIV_LEN-1:0] div_cnt;
    logic               speed_wrap;

    // A lowered display_speed below the current count lets the counter run to all-ones and wrap.
    assign speed_wrap = (speed_cnt == display_speed) || (&speed_cnt);
    assign tick       = speed_wrap && (&div_cnt);

    // Speed divisor counter feeding the binary divider on every wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_cnt <= '0;
            div_cnt   <= '0;
        end else if (clear) begin
            speed_cnt <= '0;
            div_cnt   <= '0;
        end else if (speed_wrap) begin
            speed_cnt <= '0;
            div_cnt   <= div_cnt + DIV_LEN'(1);
        end else begin
            speed_cnt <= speed_cnt + SPEED_W'(1);
        end
    end

endmodule

// File: rtl/anim_frame_gen.sv
// LED-cube animation frame generator: four selectable patterns, paced by anim_prescaler.
// Latency: frame_valid rises one cycle after a prescaler tick or after leaving IDLE.
// Backpressure: valid/ready; a presented frame and its index are held until accepted.
module anim_frame_gen
    import anim_pkg::*;
#(
    parameter int N       = 8,
    parameter int DIV_LEN = 23,
    parameter int SPEED_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [1:0]                   anim_mode,
    input  logic [SPEED_W-1:0]           display_speed,
    input  logic                         frame_ready,
    output logic                         frame_valid,
    output logic [N*N*N-1:0]             frame_cube_flat,
    output logic [$clog2(N*N+1)-1:0]     frame_idx
);

    localparam int LINES = N * N;
    localparam int IDX_W = $clog2(LINES + 1);
    localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

    state_t             state, state_d;
    logic [1:0]         mode_q, mode_d, pat_mode;
    logic [IDX_W-1:0]   step_q, step_d, pat_step, adv_step;
    logic               dir_up, dir_d, adv_dir;
    logic               load_frame, presc_clr, tick, mode_diff, accept;
    logic [N*N*N-1:0]   frame_d;

    assign frame_valid = (state == PRESENT);
    assign accept      = frame_valid & frame_ready;
    assign mode_diff   = (anim_mode != mode_q);

    anim_prescaler #(
        .DIV_LEN (DIV_LEN),
        .SPEED_W (SPEED_W)
    ) u_prescaler (
        .clk           (clk),
        .rst           (rst),
        .clear         (presc_clr),
        .display_speed (display_speed),
        .tick          (tick)
    );

    // Each cube line is either fully lit or dark, so the frame is built line by line.
    for (genvar r = 0; r < LINES; r++) begin : g_line
        assign frame_d[r*N +: N] = {N{pattern(pat_mode, int'(pat_step), r, N)}};
    end

    // Step that follows the current one in the latched mode, with bounce direction.
    always_comb begin
        adv_step = step_q + ONE;
        adv_dir  = dir_up;
        case (mode_q)
            MODE_LINE:  if (step_q == IDX_W'(LINES - 1)) adv_step = '0;
            MODE_LAYER: if (step_q == IDX_W'(N - 1))     adv_step = '0;
            MODE_BOUNCE: begin
                if (dir_up) begin
                    if (adv_step == IDX_W'(N - 1)) adv_dir = 1'b0;
                end else begin
                    adv_step = step_q - ONE;
                    if (adv_step == '0) adv_dir = 1'b1;
                end
            end
            default:    if (step_q == IDX_W'(LINES))     adv_step = '0;
        endcase
    end

    // Next state, step bookkeeping and frame-load strobe; a mode change outranks a tick.
    always_comb begin
        state_d    = state;
        mode_d     = mode_q;
        step_d     = step_q;
        dir_d      = dir_up;
        load_frame = 1'b0;
        pat_mode   = mode_q;
        pat_step   = step_q;
        presc_clr  = 1'b1;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_d    = PRESENT;
                    mode_d     = anim_mode;
                    step_d     = '0;
                    dir_d      = 1'b1;
                    load_frame = 1'b1;
                    pat_mode   = anim_mode;
                    pat_step   = '0;
                end
            end
            PRESENT: begin
                if (accept) begin
                    if (!enable) begin
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_TICK;
                        if (mode_diff) begin
                            mode_d = anim_mode;
                            step_d = '0;
                            dir_d  = 1'b1;
                        end else begin
                            step_d = adv_step;
                            dir_d  = adv_dir;
                        end
                    end
                end
            end
            WAIT_TICK: begin
                presc_clr = 1'b0;
                if (!enable) begin
                    state_d   = IDLE;
                    presc_clr = 1'b1;
                end else if (mode_diff) begin
                    mode_d    = anim_mode;
                    step_d    = '0;
                    dir_d     = 1'b1;
                    presc_clr = 1'b1;
                end else if (tick) begin
                    load_frame = 1'b1;
                    state_d    = PRESENT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Mode latch, step/direction and the presented frame registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q          <= MODE_LINE;
            step_q          <= '0;
            dir_up          <= 1'b1;
            frame_cube_flat <= '0;
            frame_idx       <= '0;
        end else begin
            mode_q <= mode_d;
            step_q <= step_d;
            dir_up <= dir_d;
            if (load_frame) begin
                frame_cube_flat <= frame_d;
                frame_idx       <= pat_step;
            end
        end
    end

endmodule

// File: tb/tb_anim_frame_gen.sv
// Self-checking bench for anim_frame_gen with N=4, DIV_LEN=2.
// Table of expected frames per mode, then hand sequences for hold, mode change, speed and reset.
// Outputs are sampled on the falling clock edge.
module tb_anim_frame_gen;

    localparam int N     = 4;
    localparam int FW    = N * N * N;
    localparam int IDX_W = $clog2(N * N + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [1:0]      anim_mode;
    logic [3:0]      display_speed;
    logic            frame_ready;
    logic            frame_valid;
    logic [FW-1:0]   frame_cube_flat;
    logic [IDX_W-1:0] frame_idx;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0]       mode;
        logic [IDX_W-1:0] idx;
        logic [FW-1:0]    flat;
        int               gap;
    } vec_t;

    vec_t tbl[$];

    anim_frame_gen #(.N(N), .DIV_LEN(2), .SPEED_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .anim_mode       (anim_mode),
        .display_speed   (display_speed),
        .frame_ready     (frame_ready),
        .frame_valid     (frame_valid),
        .frame_cube_flat (frame_cube_flat),
        .frame_idx       (frame_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Waits (bounded) for the next falling edge with frame_valid high; cyc = -1 on timeout.
    task automatic wait_frame(input int budget, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (frame_valid) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic add(input logic [1:0] m, input int idx, input logic [FW-1:0] f, input int g);
        vec_t v;
        v.mode = m;
        v.idx  = IDX_W'(idx);
        v.flat = f;
        v.gap  = g;
        tbl.push_back(v);
    endtask

    initial begin
        int cyc;
        int lay[8];
        logic [FW-1:0] held_flat;
        logic stable;

        lay = '{0, 1, 2, 3, 2, 1, 0, 1};

        // Mode 0: single line walks through all 16 lines, then wraps.
        for (int i = 0; i < 16; i++) add(2'd0, i, 64'hF << (4 * i), (i == 0) ? 1 : 5);
        add(2'd0, 0, 64'h0000_0000_0000_000F, 5);
        // Mode 2: bouncing layer.
        for (int k = 0; k < 8; k++) add(2'd2, lay[k], 64'hFFFF << (16 * lay[k]), 5);
        // Mode 3: fill, 0..16 lines lit, then back to empty.
        for (int i = 0; i <= 16; i++)
            add(2'd3, i, (i == 16) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'h1 << (4 * i)) - 64'h1, 5);
        add(2'd3, 0, 64'h0, 5);
        // Mode 1: layer sweep with wrap.
        for (int z = 0; z < 4; z++) add(2'd1, z, 64'hFFFF << (16 * z), 5);
        add(2'd1, 0, 64'h0000_0000_0000_FFFF, 5);

        rst           = 1'b1;
        enable        = 1'b0;
        anim_mode     = tbl[0].mode;
        display_speed = 4'd0;
        frame_ready   = 1'b1;
        #13;
        check("reset_valid", 64'(frame_valid), 64'h0);
        check("reset_flat", frame_cube_flat, 64'h0);
        check("reset_idx", 64'(frame_idx), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        enable = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            wait_frame(40, cyc);
            check($sformatf("tbl%0d_gap", i), 64'(cyc), 64'(tbl[i].gap));
            check($sformatf("tbl%0d_idx", i), 64'(frame_idx), 64'(tbl[i].idx));
            check($sformatf("tbl%0d_flat", i), frame_cube_flat, tbl[i].flat);
            anim_mode = (i + 1 < tbl.size()) ? tbl[i + 1].mode : 2'd0;
        end

        // Run mode 0 up to idx 7, then stall the consumer and request mode 1.
        for (int k = 0; k < 8; k++) begin
            wait_frame(40, cyc);
            check($sformatf("m0_idx%0d", k), 64'(frame_idx), 64'(k));
        end
        frame_ready = 1'b0;
        anim_mode   = 2'd1;
        held_flat   = frame_cube_flat;
        stable      = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (!frame_valid || frame_cube_flat !== held_flat || frame_idx !== IDX_W'(7)) stable = 1'b0;
        end
        check("hold_stable", 64'(stable), 64'h1);
        check("hold_flat", frame_cube_flat, 64'h0000_0000_F000_0000);
        frame_ready = 1'b1;
        wait_frame(40, cyc);
        check("after_hold_gap", 64'(cyc), 64'd5);
        check("mode1_first_idx", 64'(frame_idx), 64'h0);
        check("mode1_first_flat", frame_cube_flat, 64'h0000_0000_0000_FFFF);

        // Mode change landing on the tick cycle: the frame is withheld and the period restarts.
        repeat (4) @(negedge clk);
        anim_mode = 2'd2;
        wait_frame(40, cyc);
        check("tick_vs_mode_gap", 64'(cyc), 64'd5);
        check("tick_vs_mode_idx", 64'(frame_idx), 64'h0);
        check("tick_vs_mode_flat", frame_cube_flat, 64'h0000_0000_0000_FFFF);

        // Slower speed: 4 * 4 wait cycles plus the accept cycle.
        display_speed = 4'd3;
        wait_frame(40, cyc);
        check("speed3_gap", 64'(cyc), 64'd17);
        check("speed3_idx", 64'(frame_idx), 64'h1);
        check("speed3_flat", frame_cube_flat, 64'h0000_0000_FFFF_0000);

        // Asynchronous reset in the middle of the wait period.
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(frame_valid), 64'h0);
        check("midrst_flat", frame_cube_flat, 64'h0);
        check("midrst_idx", 64'(frame_idx), 64'h0);
        enable = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        stable = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (frame_valid) stable = 1'b0;
        end
        check("idle_no_frame", 64'(stable), 64'h1);
        enable = 1'b1;
        wait_frame(40, cyc);
        check("reenable_gap", 64'(cyc), 64'd1);
        check("reenable_idx", 64'(frame_idx), 64'h0);
        check("reenable_flat", frame_cube_flat, 64'h0000_0000_0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
